spi_cmd_seq: RTL

//  Command sequencer sitting directly upstream of spi_master. Accepts one SPI transaction
//  per valid/ready command, frames it with chip-select setup/hold/gap timing, runs the
//  spi_master wr_req/rd_req/ack four-phase handshake, captures read data masked to the bit

---
 rtl/spi_cmd_seq.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_seq.sv
// Purpose : frames one SPI transaction per command around spi_master (cs setup/hold/gap,
//           four-phase wr_req/rd_req/ack), returns masked read data as a response.
// Latency : cs_n falls 1 clk after accept, req rises P_CS_SETUP clk later; response
//           P_CS_HOLD + P_CS_GAP (+1) clk after ack falls; rejected cmds respond next clk.
// Backpressure: cmd_ready only while idle and not faulted; a response is held until rsp_ready.
// Ports   : clk/rst_n            clock, async active-low reset
//           cmd_*                valid/ready command (wr, rd, nbits, wdata)
//           rsp_*                valid/ready response (data, err)
//           fault                sticky ack-timeout flag (cleared only by reset)
//           cs_n, spi_*          chip select and spi_master handshake/data
module spi_cmd_seq #(
  parameter int P_DATA_WIDTH = 256,
  parameter int P_CS_SETUP   = 4,
  parameter int P_CS_HOLD    = 4,
  parameter int P_CS_GAP     = 8,
  parameter int P_TIMEOUT    = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic                    cmd_rd,
  input  logic [7:0]              cmd_nbits,
  input  logic [P_DATA_WIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [P_DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    fault,
  output logic                    cs_n,
  output logic                    spi_wr_req,
  output logic                    spi_rd_req,
  output logic [7:0]              spi_nbits,
  output logic [P_DATA_WIDTH-1:0] spi_wr_data,
  input  logic [P_DATA_WIDTH-1:0] spi_rd_data,
  input  logic                    spi_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_REQ, S_REL, S_HOLD, S_GAP, S_RSP, S_FAULT
  } state_t;

  // Down-counters are loaded with N-1 so that a phase lasts exactly N clocks.
  localparam logic [31:0] SETUP_LAST = (P_CS_SETUP > 0) ? 32'(P_CS_SETUP - 1) : 32'd0;
  localparam logic [31:0] HOLD_LAST  = (P_CS_HOLD  > 0) ? 32'(P_CS_HOLD  - 1) : 32'd0;
  localparam logic [31:0] GAP_LAST   = (P_CS_GAP   > 0) ? 32'(P_CS_GAP   - 1) : 32'd0;
  localparam logic [31:0] TMO_LAST   = (P_TIMEOUT  > 0) ? 32'(P_TIMEOUT  - 1) : 32'd0;

  state_t                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [31:0]             tmo_q, tmo_d;
  logic                    cs_n_q, cs_n_d;
  logic                    wr_req_q, wr_req_d;
  logic                    rd_req_q, rd_req_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [P_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    fault_q, fault_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [7:0]              nbits_q, nbits_d;
  logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [P_DATA_WIDTH-1:0] rd_masked;
  logic                    accept;
  logic                    go_gap;

  assign cmd_ready   = (state_q == S_IDLE) && !fault_q;
  assign accept      = cmd_valid && cmd_ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign fault       = fault_q;
  assign cs_n        = cs_n_q;
  assign spi_wr_req  = wr_req_q;
  assign spi_rd_req  = rd_req_q;
  assign spi_nbits   = nbits_q;
  assign spi_wr_data = wdata_q;

  // Keep only the low nbits of the read word; nbits beyond the bus width keeps all of it.
  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < P_DATA_WIDTH; i++) begin
      if (rd_q && (i < int'(nbits_q))) rd_masked[i] = spi_rd_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      cs_n_q      <= 1'b1;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      fault_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      nbits_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      cs_n_q      <= cs_n_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      fault_q     <= fault_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      nbits_q     <= nbits_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    cs_n_d      = cs_n_q;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    fault_d     = fault_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    nbits_d     = nbits_q;
    wdata_d     = wdata_q;
    go_gap      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = cmd_wr;
          rd_d    = cmd_rd;
          nbits_d = cmd_nbits;
          wdata_d = cmd_wdata;
          if ((cmd_nbits == 8'd0) || (!cmd_wr && !cmd_rd)) begin
            // Rejected command: answer immediately, the SPI bus is never touched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = S_RSP;
          end else begin
            cs_n_d = 1'b0;
            tmo_d  = '0;
            if (P_CS_SETUP > 0) begin
              cnt_d   = SETUP_LAST;
              state_d = S_SETUP;
            end else begin
              wr_req_d = cmd_wr;
              rd_req_d = cmd_rd;
              state_d  = S_REQ;
            end
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == 32'd0) begin
          wr_req_d = wr_q;
          rd_req_d = rd_q;
          tmo_d    = '0;
          state_d  = S_REQ;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_REQ: begin
        if (spi_ack) begin
          rsp_data_d = rd_masked;
          wr_req_d   = 1'b0;
          rd_req_d   = 1'b0;
          state_d    = S_REL;
        end else if ((P_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          cs_n_d   = 1'b1;
          fault_d  = 1'b1;
          state_d  = S_FAULT;
        end else if (tmo_q != 32'hFFFF_FFFF) begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      // Wait for the master to finish the four-phase handshake before releasing cs_n,
      // which also guarantees ack is low before the next request can rise.
      S_REL: begin
        if (!spi_ack) begin
          if (P_CS_HOLD > 0) begin
            cnt_d   = HOLD_LAST;
            state_d = S_HOLD;
          end else begin
            cs_n_d = 1'b1;
            go_gap = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == 32'd0) begin
          cs_n_d = 1'b1;
          go_gap = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == 32'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_FAULT: begin
        // Terminal until reset: bus parked idle, nothing offered or accepted.
        cs_n_d      = 1'b1;
        wr_req_d    = 1'b0;
        rd_req_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Entering the gap phase; a zero-length gap offers the response straight away.
    if (go_gap) begin
      if (P_CS_GAP > 0) begin
        cnt_d   = GAP_LAST;
        state_d = S_GAP;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = S_RSP;
      end
    end
  end

endmodule
